bitonic_sort_engine: RTL and testbench

BITONIC_SORT_ENGINE -- requirements
Module: bitonic_sort_engine

---
 rtl/bitonic_sort_engine.sv | 167 ++++++++++++++++
 tb/tb_bitonic_sort_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_engine.sv
`timescale 1ns/1ps
// Bitonic sorting network for DEPTH keys per vector, stable on original index, direction chosen per vector.
// Latency: L = IW*(IW+1)/2 register stages, one vector accepted per cycle when not stalled.
// Backpressure: the whole pipeline freezes while out_valid && !out_ready, and in_ready drops in the same cycle.
module bitonic_sort_engine #(
   parameter  int DEPTH  = 8,
   parameter  int WIDTH  = 32,
   parameter  bit SIGNED = 1'b0,
   localparam int IW     = $clog2(DEPTH),
   localparam int L      = IW * (IW + 1) / 2,
   localparam int CW     = $clog2(L + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_dir,
   input  logic [DEPTH-1:0][WIDTH-1:0]      in_keys,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DEPTH-1:0][WIDTH-1:0]      out_keys,
   output logic [DEPTH-1:0][IW-1:0]         out_idx,
   output logic                             out_dir,
   output logic [CW-1:0]                    inflight
);

   // Partner distance of compare stage s (merge block size k, sub-step j).
   function automatic int stage_j(input int s);
      int n;
      int r;
      n = 0;
      r = 1;
      for (int k = 2; k <= DEPTH; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (n == s) r = j;
            n = n + 1;
         end
      end
      return r;
   endfunction

   // Merge block size of compare stage s; selects the per-position direction.
   function automatic int stage_k(input int s);
      int n;
      int r;
      n = 0;
      r = 2;
      for (int k = 2; k <= DEPTH; k = k * 2) begin
         for (int j = k / 2; j >= 1; j = j / 2) begin
            if (n == s) r = k;
            n = n + 1;
         end
      end
      return r;
   endfunction

   function automatic logic key_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic r;
      if (SIGNED) r = $signed(a) < $signed(b);
      else        r = a < b;
      return r;
   endfunction

   logic                adv;
   logic                in_xfer;
   logic                out_xfer;

   // Stage registers and the compare-exchange results feeding them.
   logic [WIDTH-1:0]    rk [L][DEPTH];
   logic [IW-1:0]       ri [L][DEPTH];
   logic                rd [L];
   logic                rv [L];
   logic [WIDTH-1:0]    nk [L][DEPTH];
   logic [IW-1:0]       ni [L][DEPTH];
   logic                nd [L];
   logic                nv [L];

   assign adv       = !rv[L-1] || out_ready;
   assign in_ready  = adv;
   assign in_xfer   = in_valid && adv;
   assign out_xfer  = rv[L-1] && out_ready;
   assign out_valid = rv[L-1];
   assign out_dir   = rd[L-1];

   genvar s, e;
   generate
      for (s = 0; s < L; s++) begin : g_stage
         localparam int J = stage_j(s);
         localparam int K = stage_k(s);
         logic [WIDTH-1:0] sk [DEPTH];
         logic [IW-1:0]    si [DEPTH];
         logic             sd;

         if (s == 0) begin : g_src_in
            for (e = 0; e < DEPTH; e++) begin : g_el
               assign sk[e] = in_keys[e];
               assign si[e] = IW'(e);
            end
            assign sd    = in_dir;
            assign nv[s] = in_valid;
         end else begin : g_src_reg
            assign sk    = rk[s-1];
            assign si    = ri[s-1];
            assign sd    = rd[s-1];
            assign nv[s] = rv[s-1];
         end
         assign nd[s] = sd;

         for (e = 0; e < DEPTH; e++) begin : g_ce
            if ((e & J) == 0) begin : g_pair
               // Key direction flips with the vector dir; the index tie-break follows only the
               // network position, so equal keys end lower-index-first in both directions.
               localparam bit NDESC = (e & K) != 0;
               logic a_first;
               assign a_first = (sk[e] != sk[e+J]) ? (key_lt(sk[e], sk[e+J]) == (NDESC ^ sd))
                                                   : ((si[e] < si[e+J]) == !NDESC);
               assign nk[s][e]   = a_first ? sk[e]   : sk[e+J];
               assign nk[s][e+J] = a_first ? sk[e+J] : sk[e];
               assign ni[s][e]   = a_first ? si[e]   : si[e+J];
               assign ni[s][e+J] = a_first ? si[e+J] : si[e];
            end
         end
      end

      for (e = 0; e < DEPTH; e++) begin : g_out
         assign out_keys[e] = rk[L-1][e];
         assign out_idx[e]  = ri[L-1][e];
      end
   endgenerate

   // Advance all stages together; reset clears payload too so bubbles never carry X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s2 = 0; s2 < L; s2++) begin
            rv[s2] <= 1'b0;
            rd[s2] <= 1'b0;
            for (int e2 = 0; e2 < DEPTH; e2++) begin
               rk[s2][e2] <= '0;
               ri[s2][e2] <= '0;
            end
         end
      end else if (adv) begin
         for (int s2 = 0; s2 < L; s2++) begin
            rv[s2] <= nv[s2];
            rd[s2] <= nd[s2];
            for (int e2 = 0; e2 < DEPTH; e2++) begin
               rk[s2][e2] <= nk[s2][e2];
               ri[s2][e2] <= ni[s2][e2];
            end
         end
      end
   end

   // Occupancy count: +1 per input transfer, -1 per output transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_bitonic_sort_engine.sv
`timescale 1ns/1ps
module tb_bitonic_sort_engine;

   typedef struct packed {
      logic [7:0][7:0] keys;
      logic [7:0][2:0] idx;
      logic            dir;
   } res_t;

   typedef struct {
      int k[8];
      bit d;
      bit sg;
      int ek[8];
      int ei[8];
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_dir;
   logic [7:0][7:0]  in_keys;
   logic             out_ready;

   logic             u_in_ready, u_out_valid, u_out_dir;
   logic [7:0][7:0]  u_out_keys;
   logic [7:0][2:0]  u_out_idx;
   logic [2:0]       u_inflight;
   logic             s_in_ready, s_out_valid, s_out_dir;
   logic [7:0][7:0]  s_out_keys;
   logic [7:0][2:0]  s_out_idx;
   logic [2:0]       s_inflight;

   res_t q_u[$];
   res_t q_s[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_out_u = 0;
   int   run_cnt = 0;
   int   max_run = 0;
   int   peak = 0;
   bit   rand_rdy = 1'b0;

   bitonic_sort_engine #(.DEPTH(8), .WIDTH(8), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_dir(in_dir),
      .in_keys(in_keys), .out_valid(u_out_valid), .out_ready(out_ready), .out_keys(u_out_keys),
      .out_idx(u_out_idx), .out_dir(u_out_dir), .inflight(u_inflight));

   bitonic_sort_engine #(.DEPTH(8), .WIDTH(8), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_dir(in_dir),
      .in_keys(in_keys), .out_valid(s_out_valid), .out_ready(out_ready), .out_keys(s_out_keys),
      .out_idx(s_out_idx), .out_dir(s_out_dir), .inflight(s_inflight));

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, req);
   endtask

   // Reference: stable insertion sort, ties keep original order in both directions.
   function automatic res_t model(input logic [7:0][7:0] k, input logic d, input bit sg);
      int   key[8];
      int   ix[8];
      int   t;
      res_t r;
      for (int i = 0; i < 8; i++) begin
         key[i] = sg ? int'($signed(k[i])) : int'(k[i]);
         ix[i]  = i;
      end
      for (int i = 1; i < 8; i++) begin
         for (int j = i; j > 0; j--) begin
            if (d ? (key[j] < key[j-1]) : (key[j] > key[j-1])) begin
               t = key[j]; key[j] = key[j-1]; key[j-1] = t;
               t = ix[j];  ix[j]  = ix[j-1];  ix[j-1]  = t;
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         r.keys[i] = 8'(key[i]);
         r.idx[i]  = 3'(ix[i]);
      end
      r.dir = d;
      return r;
   endfunction

   function automatic logic [7:0][7:0] rand_vec();
      logic [7:0][7:0] v;
      int x;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 3) == 0) v[i] = 8'($urandom_range(0, 255));
         else begin
            x = $urandom_range(0, 6);
            v[i] = (x < 4) ? 8'(x) : 8'(249 + x);
         end
      end
      return v;
   endfunction

   // Scoreboard: push expectations on input transfers, pop and compare on output transfers.
   always @(negedge clk) begin
      res_t got;
      if (!rst) begin
         q_u.delete();
         q_s.delete();
         run_cnt = 0;
      end else begin
         if (u_out_valid && out_ready) begin
            run_cnt++;
            if (run_cnt > max_run) max_run = run_cnt;
         end else run_cnt = 0;
         if (32'(u_inflight) > peak) peak = 32'(u_inflight);
         if (u_out_valid && out_ready) begin
            n_out_u++;
            got.keys = u_out_keys; got.idx = u_out_idx; got.dir = u_out_dir;
            if (q_u.size() == 0) check("sb_uns_unexpected", 1'b0, got, 0);
            else begin
               res_t ex;
               ex = q_u.pop_front();
               check("sb_uns", got == ex, got, ex);
            end
         end
         if (s_out_valid && out_ready) begin
            got.keys = s_out_keys; got.idx = s_out_idx; got.dir = s_out_dir;
            if (q_s.size() == 0) check("sb_sgn_unexpected", 1'b0, got, 0);
            else begin
               res_t ex;
               ex = q_s.pop_front();
               check("sb_sgn", got == ex, got, ex);
            end
         end
         if (in_valid && u_in_ready) begin
            q_u.push_back(model(in_keys, in_dir, 1'b0));
            q_s.push_back(model(in_keys, in_dir, 1'b1));
         end
      end
   end

   // Offer one vector and hold it until accepted; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0][7:0] k, input logic d);
      bit acc;
      int w;
      acc = 1'b0;
      w = 0;
      in_keys = k;
      in_dir = d;
      in_valid = 1'b1;
      while (!acc && w < 200) begin
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = u_in_ready;
         @(posedge clk);
         #1;
         w++;
      end
      if (!acc) check("send_timeout", 1'b0, w, 0);
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      out_ready = 1'b1;
      while ((q_u.size() != 0 || q_s.size() != 0) && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain_empty", q_u.size() == 0 && q_s.size() == 0, q_u.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t            tbl[6];
      res_t            ex, got;
      int              lat;
      int              base;
      logic [7:0][7:0] v;

      tbl[0] = '{'{5,3,7,1,8,2,6,4}, 1'b1, 1'b0, '{1,2,3,4,5,6,7,8}, '{3,5,1,7,0,6,2,4}};
      tbl[1] = '{'{5,3,7,1,8,2,6,4}, 1'b0, 1'b0, '{8,7,6,5,4,3,2,1}, '{4,2,6,0,7,1,5,3}};
      tbl[2] = '{'{-1,2,2,-8,0,2,-1,5}, 1'b0, 1'b1, '{5,2,2,2,0,-1,-1,-8}, '{7,1,2,5,4,0,6,3}};
      tbl[3] = '{'{-1,2,2,-8,0,2,-1,5}, 1'b0, 1'b0, '{255,255,248,5,2,2,2,0}, '{0,6,3,7,1,2,5,4}};
      tbl[4] = '{'{-1,2,2,-8,0,2,-1,5}, 1'b1, 1'b1, '{-8,-1,-1,0,2,2,2,5}, '{3,0,6,4,1,2,5,7}};
      tbl[5] = '{'{9,9,9,9,9,9,9,9}, 1'b0, 1'b0, '{9,9,9,9,9,9,9,9}, '{0,1,2,3,4,5,6,7}};

      rst = 1'b1; in_valid = 1'b0; in_dir = 1'b0; in_keys = '0; out_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", !u_out_valid && !s_out_valid, {u_out_valid, s_out_valid}, 0);
      check("rst_inflight", u_inflight == 0 && s_inflight == 0, {u_inflight, s_inflight}, 0);
      check("rst_in_ready", u_in_ready && s_in_ready, {u_in_ready, s_in_ready}, 2'b11);
      check("rst_payload", u_out_keys == '0 && u_out_idx == '0 && !u_out_dir, {u_out_keys, u_out_idx}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, one at a time, with latency measured from the accepting edge.
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 8; i++) begin
            in_keys[i] = 8'(tbl[t].k[i]);
            ex.keys[i] = 8'(tbl[t].ek[i]);
            ex.idx[i]  = 3'(tbl[t].ei[i]);
         end
         ex.dir = tbl[t].d;
         in_dir = tbl[t].d;
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         lat = 1;
         while (!(tbl[t].sg ? s_out_valid : u_out_valid) && lat < 20) begin
            @(posedge clk);
            #1 lat++;
         end
         check("table_latency", lat == 6, lat, 6);
         if (tbl[t].sg) begin got.keys = s_out_keys; got.idx = s_out_idx; got.dir = s_out_dir; end
         else           begin got.keys = u_out_keys; got.idx = u_out_idx; got.dir = u_out_dir; end
         check("table_result", got == ex, got, ex);
         @(posedge clk);
         #1;
         check("table_inflight_zero", (tbl[t].sg ? s_inflight : u_inflight) == 0, u_inflight, 0);
      end

      // Back-to-back vectors with alternating direction.
      max_run = 0; peak = 0;
      for (int i = 0; i < 8; i++) send(rand_vec(), i[0]);
      drain();
      check("b2b_run", max_run == 8, max_run, 8);
      check("b2b_peak", peak == 6, peak, 6);

      // Backpressure: fill the pipe, stall five cycles, then release.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(rand_vec(), i[0]);
      check("bp_accepted", q_u.size() == 6, q_u.size(), 6);
      v = rand_vec();
      in_keys = v; in_dir = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_in_ready", !u_in_ready && !s_in_ready, {u_in_ready, s_in_ready}, 0);
         check("bp_inflight", u_inflight == 6, u_inflight, 6);
         if (q_u.size() > 0) begin
            got.keys = u_out_keys; got.idx = u_out_idx; got.dir = u_out_dir;
            check("bp_frozen", u_out_valid && got == q_u[0], got, q_u[0]);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(v, 1'b1);
      drain();

      // Reset with four vectors in flight.
      for (int i = 0; i < 4; i++) send(rand_vec(), i[0]);
      check("mid_inflight", u_inflight == 4, u_inflight, 4);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", !u_out_valid && !s_out_valid, {u_out_valid, s_out_valid}, 0);
      check("mid_rst_inflight", u_inflight == 0 && s_inflight == 0, {u_inflight, s_inflight}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      check("post_rst_in_ready", u_in_ready, u_in_ready, 1);
      base = n_out_u;
      in_keys = rand_vec(); in_dir = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!u_out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check("post_rst_latency", lat == 6, lat, 6);
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_count", n_out_u - base == 1, n_out_u - base, 1);

      // Random regression with random downstream stalls and idle input cycles.
      rand_rdy = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 7) == 0) idle();
         send(rand_vec(), 1'($urandom_range(0, 1)));
      end
      rand_rdy = 1'b0;
      drain();
      @(posedge clk);
      #1;
      check("final_inflight", u_inflight == 0 && s_inflight == 0, {u_inflight, s_inflight}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
